// File: rtl/full_receiver.sv
`timescale 1ns / 1ps
// Serial-to-word receiver: decodes four 8N1 frames (MSB first) into one 32-bit word,
// first byte in data[31:24], with valid strobe and framing/gap-timeout error strobe.
module full_receiver #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned GAP_BITS     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RxD,
    output logic [31:0] data,
    output logic        valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
    localparam int unsigned GapCyc  = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned GapW    = $clog2(GapCyc);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;
    logic              fall;

    assign fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    // The detect cycle itself counts as clk_cnt 0.
                    state_d   = StStart;
                    clk_cnt_d = CntW'(1);
                    gap_cnt_d = '0;
                end else if (byte_cnt_q != 2'd0) begin
                    if (gap_cnt_q == GapW'(GapCyc - 1)) begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = 2'd0;
                        gap_cnt_d  = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                if (clk_cnt_q == CntW'(HalfBit)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = rx_sync_q ? StIdle : StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (clk_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {shift_q[6:0], rx_sync_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (clk_cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
                    // Leaving mid stop bit lets a back-to-back start edge be seen.
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                    if (!rx_sync_q) begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = 2'd0;
                    end else if (byte_cnt_q == 2'd3) begin
                        data_d     = {word_q[31:8], shift_q};
                        valid_d    = 1'b1;
                        byte_cnt_d = 2'd0;
                    end else begin
                        unique case (byte_cnt_q)
                            2'd0:    word_d[31:24] = shift_q;
                            2'd1:    word_d[23:16] = shift_q;
                            default: word_d[15:8]  = shift_q;
                        endcase
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle) | (byte_cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            gap_cnt_q  <= '0;
            shift_q    <= 8'd0;
            word_q     <= 32'd0;
            data_q     <= 32'd0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q  <= RxD;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_full_receiver.sv
`timescale 1ns / 1ps
// Directed bench for full_receiver: expected words go into a queue as they are sent and are
// popped by a monitor on each valid pulse; error pulses and busy are checked at fixed steps.
module tb_full_receiver;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RxD = 1'b1;
    logic [31:0] data;
    logic        valid, frame_err, busy;

    int unsigned total = 0, bad = 0;
    int unsigned cyc = 0, n_valid = 0, n_ferr = 0;
    int unsigned v0, f0, n;
    logic [31:0] exp_q[$];

    full_receiver #(.CLKS_PER_BIT(CPB), .GAP_BITS(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RxD      (RxD),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest pending word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid || frame_err) check("valid_ferr_exclusive", valid & frame_err, 0);
            if (frame_err) n_ferr++;
            if (valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("word_data", data, exp_q.pop_front());
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle_bits);
        RxD = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 7; i >= 0; i--) begin
            RxD = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        RxD = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
        RxD = 1'b1;
        repeat (idle_bits * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int idle_bits);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i+:8], 1'b1, idle_bits);
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step(5);

        // Clean word with 2 idle bits between bytes.
        v0 = n_valid; f0 = n_ferr;
        exp_q.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF, 2);
        step(10);
        check("t1_valid_cnt", n_valid - v0, 1);
        check("t1_ferr_cnt", n_ferr - f0, 0);
        check("t1_data", data, 32'hDEADBEEF);
        check("t1_busy", busy, 0);

        // Bad stop bit on byte 2 discards the partial word.
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'hA1, 1'b1, 2);
        send_byte(8'hB2, 1'b1, 2);
        send_byte(8'hC3, 1'b0, 2);
        check("t2_ferr_cnt", n_ferr - f0, 1);
        check("t2_valid_cnt", n_valid - v0, 0);
        check("t2_data_held", data, 32'hDEADBEEF);
        check("t2_busy", busy, 0);
        exp_q.push_back(32'h12345678);
        send_word(32'h12345678, 2);
        step(10);
        check("t2_valid_after", n_valid - v0, 1);
        check("t2_data_new", data, 32'h12345678);

        // 3-cycle glitch: false start, busy drops by t0+CPB/2+1.
        v0 = n_valid; f0 = n_ferr;
        n = cyc;
        RxD = 1'b0;
        step(3);
        RxD = 1'b1;
        step(2);
        check("t3_busy_in_start", busy, 1);
        step(int'(n + 11 - cyc));
        check("t3_busy_cleared", busy, 0);
        step(40);
        check("t3_valid_cnt", n_valid - v0, 0);
        check("t3_ferr_cnt", n_ferr - f0, 0);

        // Gap timeout after two bytes: error at exactly 320 idle cycles past the stop sample.
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'hAA, 1'b1, 2);
        n = cyc;
        send_byte(8'h55, 1'b1, 0);
        while (!frame_err && cyc < n + 700) step(1);
        check("t4_ferr_seen", frame_err, 1);
        check("t4_ferr_cycle", cyc - n, 475);
        step(2);
        check("t4_ferr_cnt", n_ferr - f0, 1);
        check("t4_busy", busy, 0);
        exp_q.push_back(32'hCAFEF00D);
        send_word(32'hCAFEF00D, 1);
        step(10);
        check("t4_valid_cnt", n_valid - v0, 1);
        check("t4_data", data, 32'hCAFEF00D);

        // Asynchronous reset in the middle of byte 1.
        send_byte(8'h00, 1'b1, 1);
        RxD = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", data, 0);
        check("t5_rst_valid", valid, 0);
        check("t5_rst_ferr", frame_err, 0);
        check("t5_rst_busy", busy, 0);
        RxD = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(3);
        v0 = n_valid; f0 = n_ferr;
        exp_q.push_back(32'h00FF00FF);
        send_word(32'h00FF00FF, 1);
        step(10);
        check("t5_valid_cnt", n_valid - v0, 1);
        check("t5_data", data, 32'h00FF00FF);

        // Back-to-back words, zero idle bits.
        v0 = n_valid; f0 = n_ferr;
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'hFFFFFFFF);
        send_word(32'h01020304, 0);
        send_word(32'hFFFFFFFF, 0);
        step(20);
        check("t6_valid_cnt", n_valid - v0, 2);
        check("t6_ferr_cnt", n_ferr - f0, 0);
        check("t6_data", data, 32'hFFFFFFFF);
        check("t6_busy", busy, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_receiver.md
# full_receiver

Serial-to-word receiver forming the downstream stage of the 32-bit RS232 transmit path. It watches a single serial line, decodes four consecutive 10-bit frames (start 0, eight data bits MSB first, stop 1), and assembles them into one 32-bit word. The first received byte becomes data[31:24]. It presents the word with a one-cycle valid strobe and reports framing and inter-byte timeout errors.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be ≥ 4.
- GAP_BITS, 20, maximum idle time allowed between bytes of one word, in bit-times; the timeout is GAP_BITS*CLKS_PER_BIT cycles.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RxD  in  1  serial input; asynchronous to clk, idles high.
- data  out  32  last completed word; holds its value until the next completed word.
- valid  out  1  one-cycle pulse; data is new.
- frame_err  out  1  one-cycle pulse; a partial word was discarded.
- busy  out  1  high while a frame is in progress or a partial word is held.

## Operation
- RxD passes through a 2-flop synchronizer. The synchronizer flops reset to 1.
- FSM states are IDLE, START, DATA, STOP.
- Counters:
  - clk_cnt, 0..CLKS_PER_BIT-1.
  - bit_cnt, 0..7.
  - byte_cnt, 0..3.
  - gap_cnt, which runs only in IDLE while byte_cnt ≠ 0.
- IDLE → START on a synchronized high-to-low transition. A line held low never starts a frame.
- START:
  - At CLKS_PER_BIT/2 cycles (integer division), sample the line.
  - If the sample is 0, go to DATA with clk_cnt cleared.
  - If the sample is 1, treat it as a false start: return to IDLE. byte_cnt is unchanged and no error is raised.
- DATA:
  - Every CLKS_PER_BIT cycles, sample one bit and shift it into the LSB of the byte shift register (MSB first on the line).
  - After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample the stop bit.
  - Stop bit = 1, byte_cnt < 3: store the byte in the word assembly register at position byte_cnt, increment byte_cnt, go to IDLE.
  - Stop bit = 1, byte_cnt = 3: load data with {b0,b1,b2,b3}, pulse valid, clear byte_cnt, go to IDLE.
  - Stop bit = 0: pulse frame_err, clear byte_cnt, discard the word, go to IDLE. The next high-to-low edge restarts at byte 0.
- Gap timeout: if gap_cnt reaches GAP_BITS*CLKS_PER_BIT in IDLE with byte_cnt ≠ 0, pulse frame_err and clear byte_cnt.
- gap_cnt clears on every start detect.
- busy = (state ≠ IDLE) | (byte_cnt ≠ 0).
- valid and frame_err are never high in the same cycle.

## Timing
- Reset values (applied asynchronously): data=0, valid=0, frame_err=0, busy=0; state IDLE; all counters 0.
- Let t0 be the first cycle in which the synchronizer output is 0 after being 1. t0 is 2 clk after the RxD edge.
- Sample points:
  - Start check at t0+CLKS_PER_BIT/2.
  - Data bit k (k=0..7) at t0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
  - Stop bit at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- All outputs are registered.
  - valid and data update on the edge that samples byte 3's stop bit. valid is high for exactly that one following cycle.
  - frame_err behaves the same way on the offending stop sample or the timeout edge.
- Return to IDLE happens at the stop sample, half a bit before the stop bit ends. A start edge arriving immediately after the stop bit is therefore accepted, so back-to-back frames need zero idle bits.
- rst_n low mid-frame aborts immediately. After release, reception resumes on the next high-to-low edge.

## Test plan
- CLKS_PER_BIT=16. Send 0xDEADBEEF as bytes DE,AD,BE,EF with 2 idle bits between them → data=0xDEADBEEF, one valid pulse, frame_err never high, busy low afterwards.
- Force byte 2's stop bit to 0 → frame_err pulses once, no valid, data unchanged. Then send 0x12345678 → data=0x12345678, valid pulses.
- Drive a 3-cycle low glitch on an idle line → no valid, no frame_err. busy returns to 0 by t0+CLKS_PER_BIT/2+1.
- Send bytes 0xAA,0x55, then idle for 21 bit-times → frame_err pulses at exactly 320 cycles of idle gap. Next word 0xCAFEF00D → received correctly.
- Assert rst_n mid-byte 1 → all outputs 0 asynchronously. After release, 0x00FF00FF → received correctly.
- Send two words back-to-back with no idle bits, 0x01020304 then 0xFFFFFFFF → two valid pulses with the matching data.
